scan_seq4: RTL and testbench
============================

SCAN_SEQ4 -- requirements
Module: scan_seq4

Interface
REQ-001 Parameter DWELL_W, default 8: width of the dwell-count input.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous and active-low; it asserts immediately and is released synchronously to clk by the system reset bridge.
REQ-004 start  input  1  request to begin a scan; sampled only in IDLE.
REQ-005 stop  input  1  abort request; sampled only in RUN.
REQ-006 dir  input  1  1 = count up, 0 = count down; latched at start.
REQ-007 cont  input  1  1 = continuous scan, 0 = single pass; latched at start.
REQ-008 first  input  4  first code of the scan; latched at start.
REQ-009 last  input  4  final code of the scan; latched at start.
REQ-010 dwell  input  DWELL_W  cycles minus one each code is held; latched at start.
REQ-011 a,b,c,d  output  1 each  current 4-bit scan code (a = MSB, d = LSB), registered, for the downstream 4-to-16 line decoder.
REQ-012 en  output  1  1 while a,b,c,d is a valid selection (RUN only).
REQ-013 step  output  1  single-cycle pulse in the first cycle each new code is presented.
REQ-014 busy  output  1  1 in RUN and DONE.
REQ-015 done  output  1  single-cycle pulse when a single-pass scan completes normally.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-017 IDLE, start=1 -> next cycle RUN; code=first, en=1, step=1, dwell counter loaded with the latched dwell value.
REQ-018 IDLE, start=0 -> remain in IDLE; stop is ignored in IDLE.
REQ-019 RUN: each code SHALL be held for exactly dwell+1 cycles; dwell=0 means a new code every cycle.
REQ-020 RUN, counter=0 and code!=last -> code advances by +1 (dir=1) or -1 (dir=0) mod 16, counter reloads, step=1.
REQ-021 Wrap-around: up from 15 goes to 0 and down from 0 goes to 15; the scan passes through the wrap until it reaches last.
REQ-022 RUN, counter=0 and code=last, cont=1 -> code=first, counter reloads, step=1, stay in RUN.
REQ-023 RUN, counter=0 and code=last, cont=0 -> DONE.
REQ-024 first=last: the scan covers that one code only, for dwell+1 cycles per pass.
REQ-025 RUN, stop=1 -> IDLE next cycle with no DONE and no done pulse; stop has priority over any advance or completion in the same cycle.
REQ-026 DONE lasts one cycle: done=1, en=0, busy=1; the next state is always IDLE.
REQ-027 start asserted outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-028 In IDLE and DONE, a,b,c,d SHALL be 0000 and en=0.
REQ-029 Changes on the configuration inputs after start SHALL have no effect until the next start.

Reset
REQ-030 While rst_n=0: state=IDLE; a,b,c,d=0000; en, step, busy and done=0; counter=0; latched configuration=0.
REQ-031 A reset asserted mid-scan SHALL abort the scan immediately, with no done pulse.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the code width constant CODE_W=4.
REQ-033 The dwell timer SHALL be the single sub-module dwell_cnt (load, decrement, zero flag, width DWELL_W).

Verification
REQ-034 first=3, last=5, dir=1, cont=0, dwell=1, pulse start -> codes 3,3,4,4,5,5 with step on each change, then done pulse, then IDLE with code 0000.
REQ-035 first=14, last=1, dir=1, dwell=0 -> codes 14,15,0,1 on consecutive cycles, then done.
REQ-036 first=2, last=0, dir=0, cont=1, dwell=0 -> 2,1,0,2,1,0...; stop asserted at the second code 1 -> IDLE next cycle, en=0, no done pulse.
REQ-037 first=last=7, dwell=3 -> code 7 for 4 cycles, then done; a start pulse during RUN has no effect.
REQ-038 rst_n pulled low mid-RUN at code 9 -> all outputs 0 immediately; after release, start runs cleanly from first.
REQ-039 Counter reaches 0 at last in the same cycle stop=1 -> IDLE, no done pulse.

Source files
------------

// File: rtl/scan_seq4_pkg.sv
// -----------------------------------------------------------------------------
// scan_seq4_pkg
// Shared definitions for the 4-bit scan sequencer:
//   CODE_W     - width of the scan code driven to the 4-to-16 line decoder
//   state_e    - sequencer states (IDLE, RUN, DONE)
//   next_code  - modulo-2^CODE_W step up or down from a code
// -----------------------------------------------------------------------------
package scan_seq4_pkg;

    localparam int unsigned CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Natural overflow of the CODE_W-bit sum gives the 15->0 and 0->15 wrap.
    function automatic logic [CODE_W-1:0] next_code(
        input logic [CODE_W-1:0] code,
        input logic              up
    );
        logic [CODE_W-1:0] res;
        if (up) begin
            res = code + CODE_W'(1);
        end else begin
            res = code - CODE_W'(1);
        end
        return res;
    endfunction

endpackage : scan_seq4_pkg

// File: rtl/scan_seq4_dwell_cnt.sv
// -----------------------------------------------------------------------------
// dwell_cnt
// Down-counter that times how long each scan code is held.
// Ports:
//   clk        - rising-edge clock
//   rst_n      - asynchronous active-low reset (counter cleared to 0)
//   load_i     - load load_val_i into the counter (has priority over dec_i)
//   dec_i      - decrement by one; saturates at zero
//   load_val_i - value to load, W bits
//   zero_o     - counter currently equals zero
// -----------------------------------------------------------------------------
module dwell_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load beats decrement; never decrement past zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : dwell_cnt

// File: rtl/scan_seq4.sv
// -----------------------------------------------------------------------------
// scan_seq4
// Scan sequencer that steps a 4-bit code (a = MSB .. d = LSB) from a first to
// a last value, up or down with wrap-around, holding each code for dwell+1
// cycles. Single-pass or continuous; abortable with stop.
// Ports:
//   clk, rst_n    - clock and asynchronous active-low reset
//   start         - begin a scan (honoured in IDLE only)
//   stop          - abort a scan (honoured in RUN only)
//   dir, cont     - up/down and continuous/single-pass, latched at start
//   first, last   - scan bounds, latched at start
//   dwell         - hold time minus one per code, latched at start
//   a, b, c, d    - registered scan code, 0000 outside RUN
//   en            - code is a valid selection (RUN)
//   step          - one-cycle pulse when a new code is first presented
//   busy          - high in RUN and DONE
//   done          - one-cycle pulse when a single pass completes
// -----------------------------------------------------------------------------
module scan_seq4
    import scan_seq4_pkg::*;
#(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               cont,
    input  logic [CODE_W-1:0]  first,
    input  logic [CODE_W-1:0]  last,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               en,
    output logic               step,
    output logic               busy,
    output logic               done
);

    // FSM state and registered outputs
    state_e              state_q,  state_d;
    logic [CODE_W-1:0]   code_q,   code_d;
    logic                en_q,     en_d;
    logic                step_q,   step_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;

    // Configuration captured at start
    logic                dir_q,    dir_d;
    logic                cont_q,   cont_d;
    logic [CODE_W-1:0]   first_q,  first_d;
    logic [CODE_W-1:0]   last_q,   last_d;
    logic [DWELL_W-1:0]  dwell_q,  dwell_d;

    // Dwell timer control
    logic                cnt_load_s;
    logic                cnt_dec_s;
    logic [DWELL_W-1:0]  cnt_val_s;
    logic                cnt_zero_s;

    dwell_cnt #(
        .W (DWELL_W)
    ) u_dwell_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load_s),
        .dec_i      (cnt_dec_s),
        .load_val_i (cnt_val_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state, next-output and dwell-timer control for the sequencer.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        en_d       = en_q;
        step_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        dir_d      = dir_q;
        cont_d     = cont_q;
        first_d    = first_q;
        last_d     = last_q;
        dwell_d    = dwell_q;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        cnt_val_s  = dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Capture the whole configuration in one edge; the first
                    // code is taken straight from the inputs so it appears
                    // in the very next cycle.
                    dir_d      = dir;
                    cont_d     = cont;
                    first_d    = first;
                    last_d     = last;
                    dwell_d    = dwell;
                    cnt_load_s = 1'b1;
                    cnt_val_s  = dwell;
                    state_d    = ST_RUN;
                    code_d     = first;
                    en_d       = 1'b1;
                    step_d     = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    // Abort wins over any advance or completion this cycle.
                    state_d = ST_IDLE;
                    code_d  = '0;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_zero_s) begin
                    if (code_q != last_q) begin
                        code_d     = next_code(code_q, dir_q);
                        cnt_load_s = 1'b1;
                        step_d     = 1'b1;
                    end else if (cont_q) begin
                        code_d     = first_q;
                        cnt_load_s = 1'b1;
                        step_d     = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                        code_d  = '0;
                        en_d    = 1'b0;
                        busy_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                code_d  = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                code_d  = '0;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, outputs and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            en_q    <= 1'b0;
            step_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
            first_q <= '0;
            last_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            en_q    <= en_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
            first_q <= first_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
        end
    end

    assign a    = code_q[3];
    assign b    = code_q[2];
    assign c    = code_q[1];
    assign d    = code_q[0];
    assign en   = en_q;
    assign step = step_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : scan_seq4

// File: tb/tb_scan_seq4.sv
// -----------------------------------------------------------------------------
// tb_scan_seq4
// Directed bench for scan_seq4. Inputs change and outputs are sampled on the
// falling clock edge. Each observation is {a,b,c,d,en,step,busy,done}.
// -----------------------------------------------------------------------------
module tb_scan_seq4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       dir;
    logic       cont;
    logic [3:0] first;
    logic [3:0] last;
    logic [7:0] dwell;
    logic       a, b, c, d;
    logic       en, step, busy, done;

    int n_total;
    int n_pass;

    scan_seq4 #(
        .DWELL_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .cont  (cont),
        .first (first),
        .last  (last),
        .dwell (dwell),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .en    (en),
        .step  (step),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] outv();
        return {a, b, c, d, en, step, busy, done};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %b want %b (code,en,step,busy,done)", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock, then expect RUN with the given code and step value.
    task automatic run_chk(input string tag, input logic [3:0] code, input logic st);
        @(negedge clk);
        check(tag, outv(), {code, 1'b1, st, 1'b1, 1'b0});
    endtask

    task automatic done_chk(input string tag);
        @(negedge clk);
        check(tag, outv(), 8'b0000_0011);
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        check(tag, outv(), 8'b0000_0000);
    endtask

    task automatic cfg(input logic [3:0] f, input logic [3:0] l, input logic dr,
                       input logic ct, input logic [7:0] dw);
        first = f;
        last  = l;
        dir   = dr;
        cont  = ct;
        dwell = dw;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        cfg(4'd0, 4'd0, 1'b0, 1'b0, 8'd0);

        // Reset state
        #2;
        check("reset", outv(), 8'b0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle_chk("idle_after_reset");

        // Stop is ignored in IDLE
        stop = 1'b1;
        idle_chk("idle_stop_ignored");
        stop = 1'b0;

        // 3..5 up, single pass, dwell 1
        cfg(4'd3, 4'd5, 1'b1, 1'b0, 8'd1);
        start = 1'b1;
        run_chk("p1_3a", 4'd3, 1'b1);
        start = 1'b0;
        run_chk("p1_3b", 4'd3, 1'b0);
        run_chk("p1_4a", 4'd4, 1'b1);
        run_chk("p1_4b", 4'd4, 1'b0);
        run_chk("p1_5a", 4'd5, 1'b1);
        run_chk("p1_5b", 4'd5, 1'b0);
        done_chk("p1_done");
        idle_chk("p1_idle");

        // 14..1 up through the wrap, dwell 0
        cfg(4'd14, 4'd1, 1'b1, 1'b0, 8'd0);
        start = 1'b1;
        run_chk("p2_14", 4'd14, 1'b1);
        start = 1'b0;
        run_chk("p2_15", 4'd15, 1'b1);
        run_chk("p2_0", 4'd0, 1'b1);
        run_chk("p2_1", 4'd1, 1'b1);
        done_chk("p2_done");
        idle_chk("p2_idle");

        // 1..14 down through the wrap
        cfg(4'd1, 4'd14, 1'b0, 1'b0, 8'd0);
        start = 1'b1;
        run_chk("dn_1", 4'd1, 1'b1);
        start = 1'b0;
        run_chk("dn_0", 4'd0, 1'b1);
        run_chk("dn_15", 4'd15, 1'b1);
        run_chk("dn_14", 4'd14, 1'b1);
        done_chk("dn_done");

        // 2..0 down, continuous; stop at the second 1
        cfg(4'd2, 4'd0, 1'b0, 1'b1, 8'd0);
        @(negedge clk);
        start = 1'b1;
        run_chk("p3_2a", 4'd2, 1'b1);
        start = 1'b0;
        run_chk("p3_1a", 4'd1, 1'b1);
        run_chk("p3_0a", 4'd0, 1'b1);
        run_chk("p3_2b", 4'd2, 1'b1);
        run_chk("p3_1b", 4'd1, 1'b1);
        stop = 1'b1;
        idle_chk("p3_stop");
        stop = 1'b0;
        idle_chk("p3_no_done");

        // first=last=7, dwell 3; start and config changes during RUN ignored
        cfg(4'd7, 4'd7, 1'b1, 1'b0, 8'd3);
        start = 1'b1;
        run_chk("p4_7a", 4'd7, 1'b1);
        start = 1'b1;
        cfg(4'd1, 4'd9, 1'b0, 1'b1, 8'd0);
        run_chk("p4_7b", 4'd7, 1'b0);
        start = 1'b0;
        run_chk("p4_7c", 4'd7, 1'b0);
        run_chk("p4_7d", 4'd7, 1'b0);
        done_chk("p4_done");
        idle_chk("p4_idle");
        idle_chk("p4_not_queued");

        // Start with stop high in IDLE: stop ignored
        cfg(4'd3, 4'd3, 1'b1, 1'b0, 8'd0);
        start = 1'b1;
        stop  = 1'b1;
        run_chk("ss_run", 4'd3, 1'b1);
        start = 1'b0;
        stop  = 1'b0;
        done_chk("ss_done");
        idle_chk("ss_idle");

        // Asynchronous reset mid-RUN at code 9
        cfg(4'd8, 4'd12, 1'b1, 1'b0, 8'd0);
        start = 1'b1;
        run_chk("rs_8", 4'd8, 1'b1);
        start = 1'b0;
        run_chk("rs_9", 4'd9, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_async", outv(), 8'b0000_0000);
        @(negedge clk);
        check("rs_held", outv(), 8'b0000_0000);
        rst_n = 1'b1;
        start = 1'b1;
        run_chk("rs2_8", 4'd8, 1'b1);
        start = 1'b0;
        run_chk("rs2_9", 4'd9, 1'b1);
        run_chk("rs2_10", 4'd10, 1'b1);
        run_chk("rs2_11", 4'd11, 1'b1);
        run_chk("rs2_12", 4'd12, 1'b1);
        done_chk("rs2_done");

        // Counter hits 0 at last while stop is high: no DONE
        cfg(4'd5, 4'd5, 1'b1, 1'b0, 8'd0);
        @(negedge clk);
        start = 1'b1;
        run_chk("sl_5", 4'd5, 1'b1);
        start = 1'b0;
        stop  = 1'b1;
        idle_chk("sl_stop");
        stop = 1'b0;
        idle_chk("sl_no_done");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_scan_seq4
